mem_bus_arbiter: RTL

//  Shares one single-port synchronous memory between the core's instruction-fetch port
//  (read-only) and its data port (read/write). It sits between the core and the memory

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port synchronous memory between a read-only fetch port and a
// read/write data port. Optional round-robin arbitration via `define MEM_ARB_RR_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_grant
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_lat
      $error("mem_bus_arbiter: MEM_LAT must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                grant_q, grant_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                pick_data;

`ifdef MEM_ARB_RR_EN
  logic                last_q, last_d;
  // On a tie the port that did not win last time gets the memory.
  assign pick_data = i_d_req && (!i_if_req || !last_q);
`else
  assign pick_data = i_d_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        wr_d = 1'b0;
        if (i_if_req || i_d_req) begin
          grant_d = pick_data;
          addr_d  = pick_data ? i_d_addr : i_if_addr;
          wr_d    = pick_data && i_d_we;
          if (pick_data && i_d_we) begin
            wdata_d = i_d_wdata;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 3'(MEM_LAT - 1);
`ifdef MEM_ARB_RR_EN
        last_d  = grant_q;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Count 0 marks the cycle in which the memory presents read data.
        if (cnt_q == 3'd0) begin
          if (!wr_q) begin
            if (grant_q) d_rdata_d  = i_mem_rdata;
            else         if_rdata_d = i_mem_rdata;
          end
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_mem_en    = (state_q == S_ISSUE);
  assign o_mem_we    = o_mem_en && wr_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_if_ack    = (state_q == S_ACK) && !grant_q;
  assign o_d_ack     = (state_q == S_ACK) && grant_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_grant     = grant_q;

endmodule
